// File: rtl/chip8_sprite_blitter.sv
// CHIP-8 DXYN sprite draw: XORs an N-byte sprite into the 64x32 1bpp framebuffer in main RAM and reports VF collision.
// Define CHIP8_BLIT_CLIP_EN to clip at the screen edges instead of wrapping around.
module chip8_sprite_blitter #(
    parameter logic [11:0] FB_BASE = 12'hF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  vx,
    input  logic [7:0]  vy,
    input  logic [3:0]  n,
    input  logic [11:0] i_addr,
    output logic [11:0] address_out,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        write_enable,
    output logic        busy,
    output logic        done,
    output logic        collision
);
    typedef enum logic [3:0] {
        IDLE, SPR_A, SPR_W, L_A, L_W, L_WR, R_A, R_W, R_WR, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y0_q, y0_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  r_q, r_d;
    logic [11:0] i_q, i_d;
    logic [7:0]  spr_q, spr_d;
    logic [7:0]  fb_q, fb_d;
    logic        collision_q, collision_d;
    logic [11:0] address_q, address_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        unused_bits;
    assign unused_bits = ^{vx[7:6], vy[7:5]};

    // Sprite split across two bytes: upper half is the left byte, lower half the right byte.
    logic [15:0] parts_c;
    logic [2:0]  sh_c, col_c;
    logic [4:0]  r_inc;
    logic        has_right, row_clipped, row_end;

    assign sh_c    = x_q[2:0];
    assign col_c   = x_q[5:3];
    assign parts_c = {spr_q, 8'h00} >> sh_c;
    assign r_inc   = {1'b0, r_q} + 5'd1;

`ifdef CHIP8_BLIT_CLIP_EN
    assign has_right   = (sh_c != 3'd0) && (col_c != 3'd7);
    assign row_clipped = ({1'b0, y0_q} + {1'b0, r_inc}) > 6'd31;
`else
    assign has_right   = (sh_c != 3'd0);
    assign row_clipped = 1'b0;
`endif

    assign row_end = (r_inc == {1'b0, n_q}) || row_clipped;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y0_d        = y0_q;
        n_d         = n_q;
        r_d         = r_q;
        i_d         = i_q;
        spr_d       = spr_q;
        fb_d        = fb_q;
        collision_d = collision_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d         = vx[5:0];
                    y0_d        = vy[4:0];
                    n_d         = n;
                    i_d         = i_addr;
                    r_d         = 4'd0;
                    collision_d = 1'b0;
                    state_d     = (n == 4'd0) ? DONE : SPR_A;
                end
            end
            SPR_A: state_d = SPR_W;
            SPR_W: begin
                spr_d   = data_in;
                state_d = L_A;
            end
            L_A:   state_d = L_W;
            L_W: begin
                fb_d    = data_in;
                state_d = L_WR;
            end
            L_WR: begin
                collision_d = collision_q | (|(fb_q & parts_c[15:8]));
                if (has_right) begin
                    state_d = R_A;
                end else begin
                    r_d     = r_inc[3:0];
                    state_d = row_end ? DONE : SPR_A;
                end
            end
            R_A:   state_d = R_W;
            R_W: begin
                fb_d    = data_in;
                state_d = R_WR;
            end
            R_WR: begin
                collision_d = collision_q | (|(fb_q & parts_c[7:0]));
                r_d         = r_inc[3:0];
                state_d     = row_end ? DONE : SPR_A;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so they come straight out of flops.
    logic [4:0]  y_n;
    logic [2:0]  col_n, col_r_n, sh_n;
    logic [15:0] parts_n;
    logic [11:0] row_base_n;

    assign y_n        = y0_d + {1'b0, r_d};
    assign col_n      = x_d[5:3];
    assign col_r_n    = col_n + 3'd1;
    assign sh_n       = x_d[2:0];
    assign parts_n    = {spr_d, 8'h00} >> sh_n;
    assign row_base_n = FB_BASE + {4'h0, y_n, 3'b000};

    always_comb begin
        address_d = 12'h000;
        data_d    = 8'h00;
        we_d      = 1'b0;
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
        case (state_d)
            SPR_A, SPR_W: address_d = i_d + {8'h00, r_d};
            L_A, L_W:     address_d = row_base_n + {9'h000, col_n};
            L_WR: begin
                address_d = row_base_n + {9'h000, col_n};
                data_d    = fb_d ^ parts_n[15:8];
                we_d      = 1'b1;
            end
            R_A, R_W:     address_d = row_base_n + {9'h000, col_r_n};
            R_WR: begin
                address_d = row_base_n + {9'h000, col_r_n};
                data_d    = fb_d ^ parts_n[7:0];
                we_d      = 1'b1;
            end
            default: address_d = 12'h000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= 6'd0;
            y0_q        <= 5'd0;
            n_q         <= 4'd0;
            r_q         <= 4'd0;
            i_q         <= 12'h000;
            spr_q       <= 8'h00;
            fb_q        <= 8'h00;
            collision_q <= 1'b0;
            address_q   <= 12'h000;
            data_q      <= 8'h00;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y0_q        <= y0_d;
            n_q         <= n_d;
            r_q         <= r_d;
            i_q         <= i_d;
            spr_q       <= spr_d;
            fb_q        <= fb_d;
            collision_q <= collision_d;
            address_q   <= address_d;
            data_q      <= data_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign address_out  = address_q;
    assign data_out     = data_q;
    assign write_enable = we_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign collision    = collision_q;
endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Bench for chip8_sprite_blitter: directed table, reset/busy sequences, and random draws against a pixel-level model.
module tb_chip8_sprite_blitter;
    localparam logic [11:0] FB = 12'hF00;
`ifdef CHIP8_BLIT_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [7:0]  vx, vy;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic [11:0] address_out;
    logic [7:0]  data_in, data_out;
    logic        write_enable, busy, done, collision;

    chip8_sprite_blitter dut (
        .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy), .n(n), .i_addr(i_addr),
        .address_out(address_out), .data_in(data_in), .data_out(data_out),
        .write_enable(write_enable), .busy(busy), .done(done), .collision(collision)
    );

    logic [7:0] mem     [4096];
    logic [7:0] ref_mem [4096];
    int errors = 0;
    int checks = 0;
    int wr_count, done_count, wr_outside;

    always @(posedge clk) data_in <= mem[address_out];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge and commit any RAM write.
    task automatic tick();
        @(negedge clk);
        if (write_enable === 1'b1) begin
            wr_count++;
            if (address_out < FB) wr_outside++;
            mem[address_out] = data_out;
        end
        if (done === 1'b1) done_count++;
    endtask

    task automatic put(input int a, input logic [7:0] v);
        mem[a % 4096]     = v;
        ref_mem[a % 4096] = v;
    endtask

    task automatic clear_fb();
        for (int a = 0; a < 256; a++) put(int'(FB) + a, 8'h00);
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = -1;
        for (int a = 0; a < 4096; a++)
            if (bad < 0 && mem[a] !== ref_mem[a]) bad = a;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: mem[%03h]=%02h, expected %02h", name, bad, mem[bad], ref_mem[bad]);
        end
    endtask

    // Pixel-by-pixel DXYN on ref_mem; cycle cost from the per-row timing rule.
    task automatic model_draw(input logic [7:0] ax, input logic [7:0] ay, input logic [3:0] an,
                              input logic [11:0] ai, output bit coll, output int cyc);
        int x, y0, y, px, a, bitn;
        logic [7:0] s;
        x = int'(ax) % 64;
        y0 = int'(ay) % 32;
        coll = 1'b0;
        cyc = 1;
        for (int r = 0; r < int'(an); r++) begin
            if (CLIP && (y0 + r > 31)) break;
            y = (y0 + r) % 32;
            s = ref_mem[(int'(ai) + r) % 4096];
            cyc += ((x % 8 == 0) || (CLIP && x >= 56)) ? 5 : 8;
            for (int b = 0; b < 8; b++) begin
                if (s[7-b]) begin
                    px = x + b;
                    if (px > 63) begin
                        if (CLIP) continue;
                        px -= 64;
                    end
                    a = int'(FB) + y * 8 + px / 8;
                    bitn = 7 - px % 8;
                    if (ref_mem[a][bitn]) coll = 1'b1;
                    ref_mem[a][bitn] = ~ref_mem[a][bitn];
                end
            end
        end
    endtask

    task automatic run_draw(input string tag, input logic [7:0] ax, input logic [7:0] ay,
                            input logic [3:0] an, input logic [11:0] ai, output int cyc);
        bit busy_ok;
        vx = ax; vy = ay; n = an; i_addr = ai;
        start = 1'b1;
        wr_count = 0; done_count = 0; wr_outside = 0;
        cyc = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (cyc == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 300 cycles, expected one", tag);
        end else begin
            check({tag, "_busy_run"}, busy_ok, 1);
            check({tag, "_busy_at_done"}, busy, 0);
        end
        tick();
        check({tag, "_done_pulse"}, done_count, 1);
        check({tag, "_wr_window"}, wr_outside, 0);
    endtask

    typedef struct {
        bit clr;
        logic [7:0] vx, vy;
        logic [3:0] n;
        logic [11:0] ia;
        logic [39:0] spr;
        int ne;
        logic [4:0][19:0] ex;
        bit coll;
        int cyc;
        int nwr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cyc, mcyc, cnt;
        bit mcoll, listed;
        logic [19:0] pr;
        logic [7:0] rx, ry;
        logic [3:0] rn;
        logic [11:0] ra;

        tbl[0] = '{1'b1, 8'd0, 8'd0, 4'd5, 12'h050, 40'hF0909090F0, 5,
                   {20'hF00F0, 20'hF0890, 20'hF1090, 20'hF1890, 20'hF20F0}, 1'b0, 26, 5};
        tbl[1] = '{1'b0, 8'd0, 8'd0, 4'd5, 12'h050, 40'hF0909090F0, 5,
                   {20'hF0000, 20'hF0800, 20'hF1000, 20'hF1800, 20'hF2000}, 1'b1, 26, 5};
        tbl[2] = '{1'b1, 8'd70, 8'd33, 4'd0, 12'h400, 40'hFF00000000, 0, 100'h0, 1'b0, 1, 0};
        tbl[3] = '{1'b1, 8'd4, 8'd0, 4'd1, 12'h200, 40'hFF00000000, 2,
                   {20'hF000F, 20'hF01F0, 60'h0}, 1'b0, 9, 2};
`ifdef CHIP8_BLIT_CLIP_EN
        tbl[4] = '{1'b1, 8'd62, 8'd31, 4'd2, 12'h300, 40'hFFFF000000, 1,
                   {20'hFFF03, 80'h0}, 1'b0, 6, 1};
`else
        tbl[4] = '{1'b1, 8'd62, 8'd31, 4'd2, 12'h300, 40'hFFFF000000, 4,
                   {20'hFFF03, 20'hFF8FC, 20'hF0703, 20'hF00FC, 20'h0}, 1'b0, 17, 4};
`endif
        tbl[5] = '{1'b1, 8'd70, 8'd33, 4'd1, 12'h400, 40'hFF00000000, 2,
                   {20'hF0803, 20'hF09FC, 60'h0}, 1'b0, 9, 2};

        reset = 1'b1; start = 1'b0; vx = 8'd0; vy = 8'd0; n = 4'd0; i_addr = 12'h000;
        wr_count = 0; done_count = 0; wr_outside = 0;
        for (int a = 0; a < 4096; a++) put(a, 8'h00);
        repeat (3) tick();
        check("rst_address", address_out, 0);
        check("rst_data", data_out, 0);
        check("rst_we", write_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_collision", collision, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr) clear_fb();
            for (int r = 0; r < 5; r++) put(int'(tbl[i].ia) + r, tbl[i].spr[39 - 8*r -: 8]);
            model_draw(tbl[i].vx, tbl[i].vy, tbl[i].n, tbl[i].ia, mcoll, mcyc);
            run_draw($sformatf("t%0d", i), tbl[i].vx, tbl[i].vy, tbl[i].n, tbl[i].ia, cyc);
            check($sformatf("t%0d_cycles", i), cyc, tbl[i].cyc);
            check($sformatf("t%0d_collision", i), collision, tbl[i].coll);
            check($sformatf("t%0d_writes", i), wr_count, tbl[i].nwr);
            for (int j = 0; j < tbl[i].ne; j++) begin
                pr = tbl[i].ex[4-j];
                check($sformatf("t%0d_fb_%03h", i, pr[19:8]), mem[pr[19:8]], pr[7:0]);
            end
            cnt = 0;
            for (int a = 0; a < 256; a++) begin
                listed = 1'b0;
                for (int j = 0; j < tbl[i].ne; j++) begin
                    pr = tbl[i].ex[4-j];
                    if (int'(pr[19:8]) == int'(FB) + a) listed = 1'b1;
                end
                if (!listed && mem[int'(FB) + a] != 8'h00) cnt++;
            end
            check($sformatf("t%0d_fb_rest", i), cnt, 0);
            check_mem($sformatf("t%0d_model", i));
        end

        // Reset in L_W of row 2 (cycle 14 for 5-cycle rows): rows 0 and 1 remain drawn.
        clear_fb();
        put(12'h500, 8'hFF); put(12'h501, 8'h81); put(12'h502, 8'hFF);
        put(int'(FB), 8'hFF);
        vx = 8'd0; vy = 8'd0; n = 4'd3; i_addr = 12'h500;
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            start = 1'b0;
        end
        check("rs_coll_before", collision, 1);
        check("rs_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        check("rs_address", address_out, 0);
        check("rs_data", data_out, 0);
        check("rs_we", write_enable, 0);
        check("rs_busy", busy, 0);
        check("rs_done", done, 0);
        check("rs_collision", collision, 0);
        reset = 1'b0;
        tick();
        check("rs_idle_busy", busy, 0);
        model_draw(8'd0, 8'd0, 4'd2, 12'h500, mcoll, mcyc);
        check_mem("rs_partial");

        // Second start while busy must be ignored.
        clear_fb();
        put(12'h600, 8'hA5); put(12'h601, 8'h3C); put(12'h610, 8'hFF);
        vx = 8'd0; vy = 8'd5; n = 4'd2; i_addr = 12'h600;
        start = 1'b1;
        done_count = 0;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            start = (k == 3);
            if (k == 3) begin
                vx = 8'd30; vy = 8'd9; n = 4'd1; i_addr = 12'h610;
            end
            if (done === 1'b1 && cyc == 0) cyc = k;
        end
        check("bz_done_count", done_count, 1);
        check("bz_cycles", cyc, 11);
        model_draw(8'd0, 8'd5, 4'd2, 12'h600, mcoll, mcyc);
        check_mem("bz_mem");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) clear_fb();
            else for (int k = 0; k < 12; k++) put(int'(FB) + int'($urandom_range(0, 255)), 8'($urandom));
            rx = 8'($urandom); ry = 8'($urandom);
            rn = 4'($urandom_range(0, 15));
            ra = 12'($urandom);
            for (int r = 0; r < 16; r++) put(int'(ra) + r, 8'($urandom));
            model_draw(rx, ry, rn, ra, mcoll, mcyc);
            run_draw($sformatf("rnd%0d", t), rx, ry, rn, ra, cyc);
            check($sformatf("rnd%0d_cycles", t), cyc, mcyc);
            check($sformatf("rnd%0d_collision", t), collision, mcoll);
            check_mem($sformatf("rnd%0d_mem", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
